// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   WIDTH_DEFAULT    : default address / instruction width
//   RESET_PC_DEFAULT : default first fetch address after reset
//   PC_INC           : byte distance between sequential instructions
//   fetch_state_t    : fetch FSM encoding (FETCH=0, HOLD=1, DROP=2)
package mips_pkg;

    localparam int          WIDTH_DEFAULT    = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          PC_INC           = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/flopenr.sv
// Resettable register with load enable.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, loads RESET_VAL
//   en    : load enable, q <= d when high
//   d     : next value
//   q     : registered value
module flopenr #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one memory request at a time, holds the
// returned word for decode, and restarts the flow on redirect.
//
// Ports
//   clk, reset          : clock and synchronous active-high reset
//   imem_req/imem_addr  : request to instruction memory
//   imem_ack/imem_rdata : response; rdata sampled only with ack
//   instr_valid/instr/instr_pc/instr_ready : word handed to decode
//   redirect/redirect_target : taken branch/jump; target low bits ignored
//   state_dbg           : current FSM state for observation
//
// Handshakes
//   Memory: imem_req stays high with imem_addr stable until the cycle in which
//   imem_ack=1; that cycle completes the request. Decode: a word transfers on
//   a cycle with instr_valid=1 and instr_ready=1 and redirect=0; while
//   instr_valid=1 and no transfer happens, instr/instr_pc hold stable.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int               WIDTH    = WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             instr_ready,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_target,
    output logic [1:0]       state_dbg
);

    fetch_state_t     state, state_next;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_next;
    logic             pc_en;
    logic [WIDTH-1:0] pend_pc, pend_next;
    logic             capture;
    logic [WIDTH-1:0] target_aligned;

    // Instructions are word aligned; the two low target bits are dropped.
    assign target_aligned = redirect_target & ~WIDTH'(3);

    flopenr #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en    (pc_en),
        .d     (pc_next),
        .q     (pc)
    );

    always_comb begin
        state_next = state;
        pc_en      = 1'b0;
        pc_next    = pc;
        pend_next  = pend_pc;
        capture    = 1'b0;
        case (state)
            FETCH: begin
                if (redirect) begin
                    if (imem_ack) begin
                        // Data for the old path arrives with the redirect:
                        // drop it and refetch from the target right away.
                        pc_en   = 1'b1;
                        pc_next = target_aligned;
                    end else begin
                        // The request is in flight and must complete before
                        // the new path can be issued; park the target.
                        pend_next  = target_aligned;
                        state_next = DROP;
                    end
                end else if (imem_ack) begin
                    capture    = 1'b1;
                    pc_en      = 1'b1;
                    pc_next    = pc + WIDTH'(PC_INC);
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_en      = 1'b1;
                    pc_next    = target_aligned;
                    state_next = FETCH;
                end else if (instr_ready) begin
                    state_next = FETCH;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    // A redirect coinciding with the ack is the newest one.
                    pc_en      = 1'b1;
                    pc_next    = redirect ? target_aligned : pend_pc;
                    state_next = FETCH;
                end else if (redirect) begin
                    pend_next = target_aligned;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            pend_pc  <= '0;
            instr    <= '0;
            instr_pc <= '0;
        end else begin
            state   <= state_next;
            pend_pc <= pend_next;
            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
        end
    end

    assign imem_req    = !reset && ((state == FETCH) || (state == DROP));
    assign imem_addr   = pc;
    assign instr_valid = !reset && (state == HOLD);
    assign state_dbg   = state;

endmodule
